bus_master_port: RTL

Master-side bus interface that turns one core-side read/write command into a complete bus transaction. It drives `m_req` and `bus_util` toward the central arbiter and consumes its one-hot grant bit. It serialises header and write data onto the shared bit-serial data line and returns read data or an error to the core. It supports split transactions: a slave may park a request, and the arbiter later re-grants this master to collect the result.

---
 rtl/bus_master_port.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bus_master_port.sv
// bus_master_port
//   Master-side bus interface. Takes one core command, arbitrates for the
//   shared bus, serialises a header (SID, WR, ADDR, MSB first) plus optional
//   write data, waits for a slave ack/split, collects read data, and returns
//   a one-cycle response. Split transactions are resumed on a later re-grant.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        core command handshake (ready only in IDLE)
//   cmd_write/sid/addr/wdata   command fields, latched at acceptance
//   rsp_valid/rdata/err        one-cycle completion, read data, timeout flag
//   m_req/m_grant              arbiter request and this master's grant bit
//   bus_util                   bus-in-use (wire-ORed externally)
//   bus_dout/bus_dout_en       serial data out and its tristate enable
//   bus_din                    serial read data from slave
//   slave_ack/slave_split      slave completion / split pulses
module bus_master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int SID_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [SID_W-1:0]  cmd_sid,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              m_req,
  input  logic              m_grant,
  output logic              bus_util,
  output logic              bus_dout,
  output logic              bus_dout_en,
  input  logic              bus_din,
  input  logic              slave_ack,
  input  logic              slave_split
);

  localparam int HDR_W   = SID_W + 1 + ADDR_W;
  localparam int FRAME_W = HDR_W + DATA_W;
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, REQ, WAIT_GRANT, HDR, WDATA, WAIT_ACK, RDATA,
    RESP, RELEASE_SPLIT, SPLIT_WAIT, RESUME
  } state_t;

  state_t             state, state_next;
  logic [FRAME_W-1:0] shreg;
  logic               wr;
  logic [4:0]         bit_cnt;
  logic [7:0]         wait_cnt;
  logic [DATA_W-1:0]  rd_shift;
  logic               accept;
  logic               timeout_hit;

  assign accept      = cmd_valid & cmd_ready;
  assign timeout_hit = (state == WAIT_ACK) && !slave_ack && !slave_split &&
                       (wait_cnt == TO_LIMIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    m_req       = 1'b0;
    bus_util    = 1'b0;
    bus_dout_en = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = REQ;
      end
      REQ: begin
        m_req      = 1'b1;
        state_next = WAIT_GRANT;
      end
      WAIT_GRANT: begin
        m_req = 1'b1;
        if (m_grant) state_next = HDR;
      end
      HDR: begin
        bus_util    = 1'b1;
        bus_dout_en = 1'b1;
        if (bit_cnt == 5'(HDR_W - 1)) state_next = wr ? WDATA : WAIT_ACK;
      end
      WDATA: begin
        bus_util    = 1'b1;
        bus_dout_en = 1'b1;
        if (bit_cnt == 5'(DATA_W - 1)) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        bus_util = 1'b1;
        // Ack takes priority over a simultaneous split.
        if (slave_ack)                state_next = wr ? RESP : RDATA;
        else if (slave_split)         state_next = RELEASE_SPLIT;
        else if (wait_cnt == TO_LIMIT) state_next = RESP;
      end
      RDATA: begin
        bus_util = 1'b1;
        if (bit_cnt == 5'(DATA_W - 1)) state_next = RESP;
      end
      // Bus stays held through the response cycle; released on return to IDLE.
      RESP: begin
        bus_util   = 1'b1;
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      RELEASE_SPLIT: state_next = SPLIT_WAIT;
      SPLIT_WAIT: begin
        if (m_grant) state_next = RESUME;
      end
      RESUME: begin
        bus_util   = 1'b1;
        state_next = wr ? WAIT_ACK : RDATA;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus_dout = bus_dout_en & shreg[FRAME_W-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg     <= '0;
      wr        <= 1'b0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      rd_shift  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        shreg   <= {cmd_sid, cmd_write, cmd_addr, cmd_wdata};
        wr      <= cmd_write;
        rsp_err <= 1'b0;
      end else if (state == HDR || state == WDATA) begin
        shreg <= {shreg[FRAME_W-2:0], 1'b0};
      end

      // Bit counter restarts on every state change, so each phase counts from 0.
      if (state_next != state)
        bit_cnt <= '0;
      else if (state == HDR || state == WDATA || state == RDATA)
        bit_cnt <= bit_cnt + 5'd1;

      if (state != WAIT_ACK) wait_cnt <= '0;
      else                   wait_cnt <= wait_cnt + 8'd1;

      if (timeout_hit) rsp_err <= 1'b1;

      if (state == RDATA) begin
        rd_shift <= {rd_shift[DATA_W-2:0], bus_din};
        if (bit_cnt == 5'(DATA_W - 1))
          rsp_rdata <= {rd_shift[DATA_W-2:0], bus_din};
      end
    end
  end

endmodule
